// File: rtl/base_alu_responder.sv
// base_alu_responder: responder end of the benchmark operation interface.
// Accepts one request at a time, computes a 32-bit result and models a
// base-dependent execution cost (native base fast, other bases pay a penalty).
// Optional build macro: ALU_STATS_EN adds saturating stat_ops/stat_penalty counters.
//
// Handshake: a request is accepted on a rising clk edge where
// req_valid && req_ready; req_ready is high only in IDLE, so requests
// presented while busy are ignored (not queued) and must be held by the initiator.
module base_alu_responder #(
  parameter int NATIVE_LAT  = 1,
  parameter int PENALTY_LAT = 3,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        operation,
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  input  logic [1:0]        base_select,
  output logic [DATA_W-1:0] result,
  output logic              done,
  output logic              busy,
  output logic              error,
`ifdef ALU_STATS_EN
  output logic [15:0]       stat_ops,
  output logic [15:0]       stat_penalty,
`endif
  output logic [1:0]        dbg_state_o
);

  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DECODE  = 2'd1,
    S_EXEC    = 2'd2,
    S_RESPOND = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [1:0]        base_q, base_d;
  logic [DATA_W-1:0] res_q, res_d;        // result computed in DECODE
  logic              err_int_q, err_int_d; // error computed in DECODE
  logic              pen_q, pen_d;         // request took the penalty path
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              error_q, error_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  logic [DATA_W-1:0] calc_res;
  logic              calc_err;
  logic              calc_native;
  logic              done_set;

  // Combinational ALU on the captured request, including native-base decode
  always_comb begin
    calc_res    = '0;
    calc_err    = 1'b0;
    calc_native = 1'b0;
    case (op_q)
      4'd0: calc_res = a_q + b_q;
      4'd1: calc_res = a_q - b_q;
      4'd2: calc_res = a_q * b_q;
      4'd3: begin
        if (b_q == '0) begin
          calc_res = '1;
          calc_err = 1'b1;
        end else begin
          calc_res = a_q / b_q;
        end
      end
      4'd4: calc_res = a_q & b_q;
      4'd5: calc_res = a_q | b_q;
      4'd6: calc_res = a_q ^ b_q;
      4'd7: calc_res = a_q << b_q[4:0];
      4'd8: calc_res = a_q >> b_q[4:0];
      default: begin
        calc_res = '0;
        calc_err = 1'b1;
      end
    endcase
    case (base_q)
      2'd0: calc_native = (op_q <= 4'd2);
      2'd1: calc_native = (op_q >= 4'd3) && (op_q <= 4'd5);
      2'd2: calc_native = (op_q >= 4'd6) && (op_q <= 4'd8);
      default: begin
        // Illegal base overrides any arithmetic outcome
        calc_native = 1'b0;
        calc_res    = '0;
        calc_err    = 1'b1;
      end
    endcase
  end

  // Next-state and output-register logic for the request FSM
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    base_d    = base_q;
    res_d     = res_q;
    err_int_d = err_int_q;
    pen_d     = pen_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    error_d   = error_q;
    done_d    = done_q;
    busy_d    = busy_q;
    done_set  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d    = operation;
          a_d     = operand_a;
          b_d     = operand_b;
          base_d  = base_select;
          busy_d  = 1'b1;
          error_d = 1'b0;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        res_d     = calc_res;
        err_int_d = calc_err;
        pen_d     = !calc_native;
        cnt_d     = calc_native ? CNT_W'(NATIVE_LAT)
                                : CNT_W'(NATIVE_LAT + PENALTY_LAT);
        state_d   = S_EXEC;
      end
      S_EXEC: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= CNT_W'(1)) begin
          result_d = res_q;
          error_d  = err_int_q;
          done_d   = 1'b1;
          done_set = 1'b1;
          state_d  = S_RESPOND;
        end
      end
      S_RESPOND: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, asynchronously cleared
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      base_q    <= '0;
      res_q     <= '0;
      err_int_q <= 1'b0;
      pen_q     <= 1'b0;
      cnt_q     <= '0;
      result_q  <= '0;
      error_q   <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      base_q    <= base_d;
      res_q     <= res_d;
      err_int_q <= err_int_d;
      pen_q     <= pen_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      error_q   <= error_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

`ifdef ALU_STATS_EN
  logic [15:0] stat_ops_q, stat_penalty_q;

  // Saturating completion counters, bumped on the edge that raises done
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_ops_q     <= '0;
      stat_penalty_q <= '0;
    end else if (done_set) begin
      if (stat_ops_q != 16'hFFFF) stat_ops_q <= stat_ops_q + 16'd1;
      if (pen_q && (stat_penalty_q != 16'hFFFF)) stat_penalty_q <= stat_penalty_q + 16'd1;
    end
  end

  assign stat_ops     = stat_ops_q;
  assign stat_penalty = stat_penalty_q;
`else
  logic unused_done_set;
  assign unused_done_set = done_set;
`endif

  assign req_ready   = (state_q == S_IDLE);
  assign result      = result_q;
  assign done        = done_q;
  assign busy        = busy_q;
  assign error       = error_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_base_alu_responder.sv
// Directed testbench for base_alu_responder (default parameters).
module tb_base_alu_responder;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  operation;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [1:0]  base_select;
  logic [31:0] result;
  logic        done;
  logic        busy;
  logic        error;
  logic [1:0]  dbg_state;
`ifdef ALU_STATS_EN
  logic [15:0] stat_ops;
  logic [15:0] stat_penalty;
`endif

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  // Results of the most recent issue() call
  int          lat;
  logic [31:0] r;
  logic        e;
  logic        d_after;
  logic        b_after;
  logic        rdy_after;
  logic        rdy_ok;
  int          acc_cyc;

  base_alu_responder dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .operation   (operation),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .base_select (base_select),
    .result      (result),
    .done        (done),
    .busy        (busy),
    .error       (error),
`ifdef ALU_STATS_EN
    .stat_ops    (stat_ops),
    .stat_penalty(stat_penalty),
`endif
    .dbg_state_o (dbg_state)
  );

  // Clock and free-running cycle counter
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Drive one request, hold req_valid until done is seen, scramble inputs
  // while busy, and report latency (edges after accept) and outputs.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] base);
    int w;
    @(negedge clk);
    operation   = op;
    operand_a   = a;
    operand_b   = b;
    base_select = base;
    req_valid   = 1'b1;
    w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    #1;
    acc_cyc     = cyc;
    operand_a   = ~a;
    operand_b   = b + 32'd3;
    operation   = 4'd0;
    base_select = 2'd3;
    lat    = 0;
    rdy_ok = 1'b1;
    r      = 'x;
    e      = 1'bx;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(posedge clk);
      #1;
      if (req_ready || !busy) rdy_ok = 1'b0;
      if (done) begin
        lat = k;
        r   = result;
        e   = error;
      end
    end
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    d_after   = done;
    b_after   = busy;
    rdy_after = req_ready;
  endtask

  task automatic test_reset;
    reset     = 1'b1;
    req_valid = 1'b0;
    operation = 4'd0;
    operand_a = '0;
    operand_b = '0;
    base_select = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (req_ready !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || error !== 1'b0 ||
        result !== 32'd0 || dbg_state !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_values got rdy=%b done=%b busy=%b err=%b res=%h st=%0d exp 1 0 0 0 0 0",
               req_ready, done, busy, error, result, dbg_state);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_add;
    issue(4'd0, 32'h1234, 32'h5678, 2'd0);
    tests_run++;
    if (lat !== 2 || r !== 32'h000068AC || e !== 1'b0) begin
      tests_failed++;
      $display("FAIL add_native got lat=%0d res=%h err=%b exp lat=2 res=000068ac err=0", lat, r, e);
    end
    tests_run++;
    if (d_after !== 1'b0 || b_after !== 1'b0 || rdy_after !== 1'b1 || rdy_ok !== 1'b1) begin
      tests_failed++;
      $display("FAIL add_pulse got done=%b busy=%b rdy=%b busyok=%b exp 0 0 1 1",
               d_after, b_after, rdy_after, rdy_ok);
    end
    issue(4'd1, 32'd5, 32'd6, 2'd0);
    tests_run++;
    if (lat !== 2 || r !== 32'hFFFFFFFF || e !== 1'b0) begin
      tests_failed++;
      $display("FAIL sub_wrap got lat=%0d res=%h err=%b exp lat=2 res=ffffffff err=0", lat, r, e);
    end
  endtask

  task automatic test_mul_penalty;
    issue(4'd2, 32'hFF, 32'hAA, 2'd1);
    tests_run++;
    if (lat !== 5 || r !== 32'h0000A956 || e !== 1'b0) begin
      tests_failed++;
      $display("FAIL mul_penalty got lat=%0d res=%h err=%b exp lat=5 res=0000a956 err=0", lat, r, e);
    end
`ifdef ALU_STATS_EN
    tests_run++;
    if (stat_ops !== 16'd3 || stat_penalty !== 16'd1) begin
      tests_failed++;
      $display("FAIL stats_after_mul got ops=%0d pen=%0d exp ops=3 pen=1", stat_ops, stat_penalty);
    end
`endif
  endtask

  task automatic test_div;
    issue(4'd3, 32'd100, 32'd10, 2'd1);
    tests_run++;
    if (lat !== 2 || r !== 32'd10 || e !== 1'b0) begin
      tests_failed++;
      $display("FAIL div_native got lat=%0d res=%h err=%b exp lat=2 res=0000000a err=0", lat, r, e);
    end
    issue(4'd3, 32'd7, 32'd0, 2'd1);
    tests_run++;
    if (lat !== 2 || r !== 32'hFFFFFFFF || e !== 1'b1) begin
      tests_failed++;
      $display("FAIL div_by_zero got lat=%0d res=%h err=%b exp lat=2 res=ffffffff err=1", lat, r, e);
    end
    issue(4'd3, 32'd9, 32'd2, 2'd0);
    tests_run++;
    if (lat !== 5 || r !== 32'd4 || e !== 1'b0) begin
      tests_failed++;
      $display("FAIL div_nonnative got lat=%0d res=%h err=%b exp lat=5 res=00000004 err=0", lat, r, e);
    end
  endtask

  task automatic test_shift;
    issue(4'd8, 32'd144, 32'd4, 2'd2);
    tests_run++;
    if (lat !== 2 || r !== 32'd9 || e !== 1'b0) begin
      tests_failed++;
      $display("FAIL shr got lat=%0d res=%h err=%b exp lat=2 res=00000009 err=0", lat, r, e);
    end
    issue(4'd7, 32'd24, 32'h22, 2'd2);
    tests_run++;
    if (lat !== 2 || r !== 32'd96 || e !== 1'b0) begin
      tests_failed++;
      $display("FAIL shl_masked got lat=%0d res=%h err=%b exp lat=2 res=00000060 err=0", lat, r, e);
    end
  endtask

  task automatic test_logic;
    issue(4'd4, 32'hF0F0F0F0, 32'h0FF00FF0, 2'd1);
    tests_run++;
    if (lat !== 2 || r !== 32'h00F000F0 || e !== 1'b0) begin
      tests_failed++;
      $display("FAIL and_op got lat=%0d res=%h err=%b exp lat=2 res=00f000f0 err=0", lat, r, e);
    end
    issue(4'd6, 32'hFFFF0000, 32'h0F0F0F0F, 2'd2);
    tests_run++;
    if (lat !== 2 || r !== 32'hF0F00F0F || e !== 1'b0) begin
      tests_failed++;
      $display("FAIL xor_op got lat=%0d res=%h err=%b exp lat=2 res=f0f00f0f err=0", lat, r, e);
    end
    issue(4'd5, 32'h1200, 32'h0034, 2'd0);
    tests_run++;
    if (lat !== 5 || r !== 32'h00001234 || e !== 1'b0) begin
      tests_failed++;
      $display("FAIL or_nonnative got lat=%0d res=%h err=%b exp lat=5 res=00001234 err=0", lat, r, e);
    end
  endtask

  task automatic test_illegal;
    issue(4'd12, 32'd5, 32'd6, 2'd0);
    tests_run++;
    if (lat !== 5 || r !== 32'd0 || e !== 1'b1) begin
      tests_failed++;
      $display("FAIL illegal_op got lat=%0d res=%h err=%b exp lat=5 res=00000000 err=1", lat, r, e);
    end
    tests_run++;
    if (rdy_ok !== 1'b1 || b_after !== 1'b0 || rdy_after !== 1'b1) begin
      tests_failed++;
      $display("FAIL illegal_op_hold got busyok=%b busy=%b rdy=%b exp 1 0 1", rdy_ok, b_after, rdy_after);
    end
    issue(4'd0, 32'd5, 32'd6, 2'd3);
    tests_run++;
    if (lat !== 5 || r !== 32'd0 || e !== 1'b1) begin
      tests_failed++;
      $display("FAIL illegal_base got lat=%0d res=%h err=%b exp lat=5 res=00000000 err=1", lat, r, e);
    end
  endtask

  task automatic test_back_to_back;
    int first_acc;
    issue(4'd0, 32'd1, 32'd2, 2'd0);
    first_acc = acc_cyc;
    tests_run++;
    if (r !== 32'd3 || e !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_first got res=%h err=%b exp res=00000003 err=0", r, e);
    end
    issue(4'd0, 32'd3, 32'd4, 2'd0);
    tests_run++;
    if (r !== 32'd7 || lat !== 2 || (acc_cyc - first_acc) !== 4) begin
      tests_failed++;
      $display("FAIL b2b_second got res=%h lat=%0d spacing=%0d exp res=00000007 lat=2 spacing=4",
               r, lat, acc_cyc - first_acc);
    end
  endtask

  task automatic test_reset_mid;
    int spurious;
    @(negedge clk);
    operation   = 4'd2;
    operand_a   = 32'd3;
    operand_b   = 32'd3;
    base_select = 2'd1;
    req_valid   = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (dbg_state !== 2'd2 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_in_exec got st=%0d busy=%b exp st=2 busy=1", dbg_state, busy);
    end
    reset = 1'b1;
    #1;
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0 || error !== 1'b0 || result !== 32'd0 || req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_reset_async got done=%b busy=%b err=%b res=%h rdy=%b exp 0 0 0 0 1",
               done, busy, error, result, req_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    spurious = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (done || !req_ready || busy) spurious++;
    end
    tests_run++;
    if (spurious !== 0) begin
      tests_failed++;
      $display("FAIL mid_reset_quiet got %0d bad cycles exp 0", spurious);
    end
    issue(4'd0, 32'h1234, 32'h5678, 2'd0);
    tests_run++;
    if (lat !== 2 || r !== 32'h000068AC || e !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset_fresh_add got lat=%0d res=%h err=%b exp lat=2 res=000068ac err=0", lat, r, e);
    end
`ifdef ALU_STATS_EN
    tests_run++;
    if (stat_ops !== 16'd1 || stat_penalty !== 16'd0) begin
      tests_failed++;
      $display("FAIL stats_after_reset got ops=%0d pen=%0d exp ops=1 pen=0", stat_ops, stat_penalty);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul_penalty();
    test_div();
    test_shift();
    test_logic();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
